cache_ubits_ctl: RTL and testbench
==================================

# cache_ubits_ctl

- Parametrised successor to the fixed two-way cache used-bit PAL.
- Keeps a per-set instruction-used (UBI) and data-used (UBD) bit for a WAYS-way, SETS-deep cache.
- Drives USED_n, the write-cycle-allocate strobe WCA_n and a registered IHIT_n, and adds a round-robin victim pointer, multi-hit detection and a self-timed flush sequencer.
- Sits between the tag comparators and the cache cycle control, clocked by the cache clock.

## Interface
- WAYS, 2: number of ways (2..8); one HIT_n bit per way.
- SETS, 256: number of sets (power of two, ≥4); SET_W = $clog2(SETS).
- CLK  in  1  cache clock; all state changes on rising edge.
- RESET_n  in  1  reset, synchronous, active-low.
- CYD  in  1  cache cycle valid this clock.
- RT_n, DT_n  in  1 each  cycle type: fetch = RT & ~DT, read = RT & DT, write = ~RT & DT; ~RT & ~DT is a no-op.
- SET_ADDR  in  SET_W  set index of current cycle.
- HIT_n  in  WAYS  per-way tag hit, active-low.
- FMISS  in  1  forced miss.
- LSHADOW  in  1  address in shadow region.
- EWC_n  in  1  enable write/allocate, active-low.
- FLUSH  in  1  flush request pulse.
- USED_n  out  1  used bit set for this cycle type, active-low.
- WCA_n  out  1  allocate this cycle, active-low.
- IHIT_n  out  1  registered hit-and-used, active-low.
- VICTIM  out  WAYS  one-hot way selected for allocation.
- FLUSH_BUSY  out  1  flush in progress.
- MHIT_ERR  out  1  sticky: more than one way hit.

## Operation
- anyhit = |~HIT_n; mhit = two or more HIT_n bits low.
- Per-set state: UBI, UBD, and PTR ($clog2(WAYS) bits).
- act = CYD & ~FLUSH_BUSY.
- USED = act & ~WCA & ((fetch & UBI[set]) | (read & UBD[set])). USED_n = ~USED.
- WCA = act & EWC & ~FMISS & ~LSHADOW & (write | (RT & ~anyhit)). WCA_n = ~WCA.
- VICTIM = one-hot of PTR[SET_ADDR].
- Update on the edge ending an act cycle:
  - fetch: UBI ← 1.
  - read: UBD ← 1.
  - write & anyhit: UBI ← 0; UBD unchanged.
  - WCA: PTR ← (PTR+1) mod WAYS, wrapping WAYS-1 → 0. When WAYS is not a power of two, PTR never takes values ≥ WAYS.
- IHIT register ← act & anyhit & USED.
- MHIT_ERR set on any act cycle with mhit. Cleared only by reset or by flush start.
- Bypass: a cycle reading the same set that was updated on the previous edge sees the new UBI/UBD/PTR. The array write is visible combinationally in the following cycle.
- Flush FSM, IDLE → FLUSH → IDLE:
  - FLUSH state clears one set per clock (UBI = UBD = 0, PTR = 0), walking index 0..SETS-1.
  - IDLE → FLUSH on FLUSH = 1.
  - FLUSH → IDLE after index SETS-1 is cleared.
  - FLUSH input is ignored while already in FLUSH.
  - During flush, CYD is ignored: USED_n = WCA_n = 1, and the IHIT register loads 0.

## Timing
- Reset state is FLUSH, index 0. Outputs during and right after reset:
  - FLUSH_BUSY = 1.
  - IHIT_n = 1.
  - MHIT_ERR = 0.
  - USED_n = WCA_n = 1.
  - VICTIM = way 0.
- After RESET_n deasserts, the flush runs SETS cycles; FLUSH_BUSY falls on the edge that clears set SETS-1.
- Reset asserted mid-flush restarts the flush from index 0.
- USED_n, WCA_n and VICTIM are combinational, valid in the CYD cycle.
- IHIT_n reflects that cycle one clock later.
- FLUSH asserted in IDLE: FLUSH_BUSY = 1 from the next clock, for exactly SETS cycles.
- FLUSH coincident with CYD: the CYD cycle completes normally, then the flush starts.
- Write with hit and FMISS together: UBI is cleared, WCA = 0.

## Configuration
- CACHE_UBITS_SHADOW_EN defined: LSHADOW gates WCA as above.
- CACHE_UBITS_SHADOW_EN undefined: the LSHADOW port remains but is ignored (treated as 0), so allocation is possible in the shadow region.

## Structure
- Shared package cache_pkg:
  - cycle-type enum (NOP, FETCH, READ, WRITE) and its decode function from RT_n/DT_n;
  - flush FSM state enum;
  - helper for one-hot from index.
- One sub-module, cache_ubits_array: SETS-entry register array with one read port, one write port, the flush clear port and the same-set bypass.

## Test plan
- Reset, then hold RESET_n = 1 → FLUSH_BUSY = 1 for 256 cycles (SETS = 256), USED_n = WCA_n = 1 throughout, MHIT_ERR = 0.
- Fetch set 5 with HIT_n = 2'b10 → USED_n = 1, UBI[5] = 1; second fetch set 5 → USED_n = 0, IHIT_n = 0 one clock later.
- Write set 5 with a hit, then fetch set 5 next cycle → UBI cleared and bypassed, so USED_n = 1.
- Fetch with no hit, EWC_n = 0, FMISS = 0, LSHADOW = 0 → WCA_n = 0 and VICTIM advances 01 → 10 → 01 on three allocates to one set.
- Repeat with LSHADOW = 1:
  - with the macro defined → WCA_n = 1;
  - with the macro undefined → WCA_n = 0.
- HIT_n = 2'b00 on a read → MHIT_ERR = 1 and sticky; FLUSH pulse → MHIT_ERR = 0 and FLUSH_BUSY high for SETS cycles while CYD is ignored.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the cache used-bit controller
// Provides the cycle-type enum and decoder, the flush FSM states and a one-hot helper.
package cache_pkg;
  typedef enum logic [1:0] {NOP, FETCH, READ, WRITE} cyc_t;
  typedef enum logic {S_IDLE, S_FLUSH} fsm_t;
  // rt = ~rt_n, dt = ~dt_n: fetch = rt & ~dt, read = rt & dt, write = ~rt & dt
  function automatic cyc_t cyc_decode(input logic rt_n, input logic dt_n);
    return !rt_n ? (!dt_n ? READ : FETCH) : (!dt_n ? WRITE : NOP);
  endfunction
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction
endpackage

// File: rtl/cache_ubits_ctl_if.sv
// cache_ubits_ctl_if: tag-side / cycle-control bus of the used-bit controller
// master drives cyd, rt_n, dt_n, set_addr, hit_n, fmiss, lshadow, ewc_n, flush;
// slave drives used_n, wca_n, ihit_n, victim, flush_busy, mhit_err.
interface cache_ubits_ctl_if #(parameter int WAYS = 2, parameter int SETS = 256);
  localparam int SET_W = $clog2(SETS);
  logic cyd, rt_n, dt_n, fmiss, lshadow, ewc_n, flush;
  logic [SET_W-1:0] set_addr;
  logic [WAYS-1:0] hit_n, victim;
  logic used_n, wca_n, ihit_n, flush_busy, mhit_err;
  modport master(output cyd, rt_n, dt_n, set_addr, hit_n, fmiss, lshadow, ewc_n, flush,
                 input used_n, wca_n, ihit_n, victim, flush_busy, mhit_err);
  modport slave(input cyd, rt_n, dt_n, set_addr, hit_n, fmiss, lshadow, ewc_n, flush,
                output used_n, wca_n, ihit_n, victim, flush_busy, mhit_err);
endinterface

// File: rtl/cache_ubits_array.sv
// cache_ubits_array: per-set {ubi, ubd, ptr} register array
// Ports: clk; read port i_rd_addr -> o_rd_ubi/o_rd_ubd/o_rd_ptr; write port i_wr_*;
// flush clear port i_clr_en/i_clr_addr (has priority over the write port).
module cache_ubits_array #(parameter int SETS = 256, parameter int PW = 1) (
  input  logic                    clk,
  input  logic [$clog2(SETS)-1:0] i_rd_addr,
  output logic                    o_rd_ubi,
  output logic                    o_rd_ubd,
  output logic [PW-1:0]           o_rd_ptr,
  input  logic                    i_wr_en,
  input  logic [$clog2(SETS)-1:0] i_wr_addr,
  input  logic                    i_wr_ubi,
  input  logic                    i_wr_ubd,
  input  logic [PW-1:0]           i_wr_ptr,
  input  logic                    i_clr_en,
  input  logic [$clog2(SETS)-1:0] i_clr_addr
);
  logic [PW+1:0] r_mem [SETS];
  always_ff @(posedge clk) begin
    if (i_clr_en) r_mem[i_clr_addr] <= '0;
    else if (i_wr_en) r_mem[i_wr_addr] <= {i_wr_ubi, i_wr_ubd, i_wr_ptr};
  end
  // Asynchronous read of the flop array: an update made on the previous edge
  // is already visible, which provides the same-set bypass.
  assign {o_rd_ubi, o_rd_ubd, o_rd_ptr} = r_mem[i_rd_addr];
endmodule

// File: rtl/cache_ubits_ctl.sv
// cache_ubits_ctl: cache used-bit, allocate, victim and flush controller
// Ports: clk, reset_n (synchronous, active-low), bus (cache_ubits_ctl_if.slave).
// Optional: CACHE_UBITS_SHADOW_EN makes lshadow block allocation; otherwise lshadow is ignored.
module cache_ubits_ctl import cache_pkg::*; #(parameter int WAYS = 2, parameter int SETS = 256) (
  input logic              clk,
  input logic              reset_n,
  cache_ubits_ctl_if.slave bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int PW = $clog2(WAYS);
  fsm_t r_state, w_state_nx;
  logic [SET_W-1:0] r_idx, w_idx_nx;
  logic r_ihit, r_mhit;
  cyc_t w_cyc;
  logic w_busy, w_act, w_anyhit, w_mhit, w_shadow, w_wca, w_used, w_flush_go;
  logic w_ubi, w_ubd, w_nubi, w_nubd;
  logic [PW-1:0] w_ptr, w_nptr;
`ifdef CACHE_UBITS_SHADOW_EN
  assign w_shadow = bus.lshadow;
`else
  logic w_unused_lshadow;
  assign w_unused_lshadow = bus.lshadow;
  assign w_shadow = 1'b0;
`endif
  cache_ubits_array #(.SETS(SETS), .PW(PW)) u_array (
    .clk(clk),
    .i_rd_addr(bus.set_addr),
    .o_rd_ubi(w_ubi),
    .o_rd_ubd(w_ubd),
    .o_rd_ptr(w_ptr),
    .i_wr_en(w_act),
    .i_wr_addr(bus.set_addr),
    .i_wr_ubi(w_nubi),
    .i_wr_ubd(w_nubd),
    .i_wr_ptr(w_nptr),
    .i_clr_en(w_busy),
    .i_clr_addr(r_idx)
  );
  always_comb begin
    w_cyc = cyc_decode(bus.rt_n, bus.dt_n);
    w_busy = r_state == S_FLUSH;
    w_act = bus.cyd & ~w_busy;
    w_anyhit = ~&bus.hit_n;
    w_mhit = $countones(~bus.hit_n) > 1;
    w_wca = w_act & ~bus.ewc_n & ~bus.fmiss & ~w_shadow & ((w_cyc == WRITE) | (~bus.rt_n & ~w_anyhit));
    w_used = w_act & ~w_wca & (((w_cyc == FETCH) & w_ubi) | ((w_cyc == READ) & w_ubd));
    w_nubi = (w_cyc == FETCH) ? 1'b1 : ((w_cyc == WRITE) & w_anyhit) ? 1'b0 : w_ubi;
    w_nubd = (w_cyc == READ) | w_ubd;
    // explicit wrap keeps the pointer below WAYS when WAYS is not a power of two
    w_nptr = ~w_wca ? w_ptr : (w_ptr == PW'(WAYS - 1)) ? '0 : w_ptr + 1'b1;
    w_flush_go = ~w_busy & bus.flush;
  end
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx = r_idx;
    w_state_nx = w_busy ? ((r_idx == SET_W'(SETS - 1)) ? S_IDLE : S_FLUSH) : (bus.flush ? S_FLUSH : S_IDLE);
    w_idx_nx = w_busy ? r_idx + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FLUSH;
      r_idx <= '0;
      r_ihit <= 1'b0;
      r_mhit <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx <= w_idx_nx;
      r_ihit <= w_act & w_anyhit & w_used;
      r_mhit <= ~w_flush_go & (r_mhit | (w_act & w_mhit));
    end
  end
  assign bus.used_n = ~w_used;
  assign bus.wca_n = ~w_wca;
  assign bus.ihit_n = ~r_ihit;
  // array contents are undefined until the flush has swept them, so report way 0 while busy
  assign bus.victim = w_busy ? WAYS'(1) : WAYS'(onehot(3'(w_ptr)));
  assign bus.flush_busy = w_busy;
  assign bus.mhit_err = r_mhit;
endmodule

// File: tb/tb_cache_ubits_ctl.sv
// tb_cache_ubits_ctl: scoreboard bench for cache_ubits_ctl against a set-level reference model
module tb_cache_ubits_ctl;
  localparam int WAYS = 2;
  localparam int SETS = 256;
  localparam int SET_W = $clog2(SETS);
`ifdef CACHE_UBITS_SHADOW_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif
  localparam logic [1:0] FE = 2'b01, RD = 2'b00, WR = 2'b10, NP = 2'b11;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  cache_ubits_ctl_if #(.WAYS(WAYS), .SETS(SETS)) bus();
  cache_ubits_ctl #(.WAYS(WAYS), .SETS(SETS)) dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic used_n, wca_n, ihit_n, busy, mhit;
    logic [WAYS-1:0] vic;
    bit chk_vic;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  bit m_ubi[SETS];
  bit m_ubd[SETS];
  int m_ptr[SETS];
  int m_left;
  bit m_mhit, m_ihit;
  function automatic void chk(string n, logic [7:0] a, logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("used_n", 8'(bus.used_n), 8'(e.used_n));
      chk("wca_n", 8'(bus.wca_n), 8'(e.wca_n));
      chk("ihit_n", 8'(bus.ihit_n), 8'(e.ihit_n));
      chk("flush_busy", 8'(bus.flush_busy), 8'(e.busy));
      chk("mhit_err", 8'(bus.mhit_err), 8'(e.mhit));
      if (e.chk_vic) chk("victim", 8'(bus.victim), 8'(e.vic));
    end
  end
  function automatic void model_clear();
    for (int i = 0; i < SETS; i++) begin
      m_ubi[i] = 1'b0;
      m_ubd[i] = 1'b0;
      m_ptr[i] = 0;
    end
  endfunction
  task automatic step(input logic rn, input logic cy, input logic [1:0] ty, input int sa,
                      input logic [WAYS-1:0] hn, input logic fm, input logic ls, input logic ewn, input logic fl);
    exp_t e;
    bit busy, act, rt, fetch, rd, wr, anyhit, sh, wca, used;
    int nh;
    reset_n = rn;
    bus.cyd = cy;
    bus.rt_n = ty[1];
    bus.dt_n = ty[0];
    bus.set_addr = SET_W'(sa);
    bus.hit_n = hn;
    bus.fmiss = fm;
    bus.lshadow = ls;
    bus.ewc_n = ewn;
    bus.flush = fl;
    busy = m_left > 0;
    act = cy && !busy;
    rt = !ty[1];
    fetch = rt && ty[0];
    rd = rt && !ty[0];
    wr = !rt && !ty[0];
    nh = 0;
    for (int k = 0; k < WAYS; k++) if (!hn[k]) nh++;
    anyhit = nh > 0;
    sh = SH_EN && ls;
    wca = act && !ewn && !fm && !sh && (wr || (rt && !anyhit));
    used = act && !wca && ((fetch && m_ubi[sa]) || (rd && m_ubd[sa]));
    e.used_n = !used;
    e.wca_n = !wca;
    e.ihit_n = !m_ihit;
    e.busy = busy;
    e.mhit = m_mhit;
    e.vic = busy ? WAYS'(1) : WAYS'(1 << m_ptr[sa]);
    e.chk_vic = !busy || !rn;
    q.push_back(e);
    @(posedge clk);
    if (!rn) begin
      m_left = SETS;
      m_mhit = 1'b0;
      m_ihit = 1'b0;
      model_clear();
    end else if (busy) begin
      m_left--;
      m_ihit = 1'b0;
    end else begin
      m_ihit = act && anyhit && used;
      if (act) begin
        if (fetch) m_ubi[sa] = 1'b1;
        if (rd) m_ubd[sa] = 1'b1;
        if (wr && anyhit) m_ubi[sa] = 1'b0;
        if (wca) m_ptr[sa] = (m_ptr[sa] + 1) % WAYS;
        if (nh > 1) m_mhit = 1'b1;
      end
      if (fl) begin
        m_left = SETS;
        m_mhit = 1'b0;
        model_clear();
      end
    end
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, NP, 0, '1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic drain();
    for (int i = 0; i < SETS + 8 && m_left > 0; i++)
      step(1'b1, 1'b1, 2'($urandom), $urandom_range(0, 7), WAYS'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rand_step();
    logic [WAYS-1:0] hn;
    int r;
    r = $urandom_range(0, 9);
    hn = (r < 4) ? '1 : (r < 9) ? ~WAYS'(1 << $urandom_range(0, WAYS - 1)) : '0;
    step($urandom_range(0, 999) != 0, $urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 7), hn,
         $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
  endtask
  initial begin
    bus.cyd = 1'b0;
    bus.rt_n = 1'b1;
    bus.dt_n = 1'b1;
    bus.set_addr = '0;
    bus.hit_n = '1;
    bus.fmiss = 1'b0;
    bus.lshadow = 1'b0;
    bus.ewc_n = 1'b1;
    bus.flush = 1'b0;
    model_clear();
    m_left = SETS;
    m_mhit = 1'b0;
    m_ihit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) step(1'b0, 1'b1, FE, 5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < SETS; i++) step(1'b1, 1'b1, FE, $urandom_range(0, 7), '1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    repeat (2) step(1'b1, 1'b1, FE, 5, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b1, WR, 5, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, FE, 5, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, FE, 9, '1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, FE, 9, '1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, FE, 5, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, WR, 5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, FE, 5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, RD, 3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, NP, 0, '1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, FE, 3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, FE, 3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    idle(1);
    step(1'b1, 1'b1, RD, 7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    repeat (2) step(1'b1, 1'b1, RD, 7, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1500; i++) rand_step();
    drain();
    idle(2);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
